// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating counter of inserted load-use bubbles.
module id_ex_pipe_reg #(
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              id_valid,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       id_busA,
  input  logic [31:0]       id_busB,
  input  logic [31:0]       id_signExtImm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_shamt,
  input  logic              id_usesRt,
  input  logic              id_memRead,
  input  logic              id_regWrite,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_busA,
  output logic [31:0]       ex_busB,
  output logic [31:0]       ex_signExtImm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic              ex_memRead,
  output logic              ex_regWrite,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic load_use;
  logic bubble;

  // Load in EX whose destination feeds an operand of the instruction in ID.
  always_comb begin
    load_use     = 1'b0;
    hazard_stall = 1'b0;
    if (ex_valid && ex_memRead && (ex_rt != 5'd0) && id_valid) begin
      load_use = (ex_rt == id_rs) || (id_usesRt && (ex_rt == id_rt));
    end
    hazard_stall = load_use && !flush && !ex_hold;
  end

  assign bubble = !ex_hold && (flush || hazard_stall);

  // Pipeline register: reset and bubbles clear everything, hold freezes.
  always_ff @(posedge CLK) begin
    if (!Reset_L || bubble) begin
      ex_valid      <= 1'b0;
      ex_pc4        <= 32'd0;
      ex_busA       <= 32'd0;
      ex_busB       <= 32'd0;
      ex_signExtImm <= 32'd0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
      ex_rd         <= 5'd0;
      ex_shamt      <= 5'd0;
      ex_memRead    <= 1'b0;
      ex_regWrite   <= 1'b0;
      ex_ctrl       <= '0;
    end else if (!ex_hold) begin
      ex_valid      <= id_valid;
      ex_pc4        <= id_pc4;
      ex_busA       <= id_busA;
      ex_busB       <= id_busB;
      ex_signExtImm <= id_signExtImm;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_shamt      <= id_shamt;
      ex_memRead    <= id_valid && id_memRead;
      ex_regWrite   <= id_valid && id_regWrite;
      ex_ctrl       <= id_valid ? id_ctrl : '0;
    end
  end

  // Only load-use bubbles are counted; flush bubbles are not.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      bubble_cnt <= '0;
    end else if (hazard_stall && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed table, hold/saturation
// sequences and randomized traffic against a transaction-level model.
module tb_id_ex_pipe_reg;

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic        memRead;
    logic        regWrite;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  typedef struct packed {
    logic        rst_n;
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic        usesRt;
    logic        memRead;
    logic        regWrite;
    logic [CTRL_W-1:0] ctrl;
    logic        flush;
    logic        hold;
  } in_t;

  typedef struct {
    in_t         v;
    bit          chk_stall;
    logic        stall;
    logic        valid;
    logic [4:0]  rt;
    logic        rw;
    logic [31:0] imm;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic              CLK = 1'b0;
  logic              Reset_L;
  logic              id_valid, id_usesRt, id_memRead, id_regWrite, flush, ex_hold;
  logic [31:0]       id_pc4, id_busA, id_busB, id_signExtImm;
  logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid, ex_memRead, ex_regWrite, hazard_stall;
  logic [31:0]       ex_pc4, ex_busA, ex_busB, ex_signExtImm;
  logic [4:0]        ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_pipe_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_busA(id_busA), .id_busB(id_busB), .id_signExtImm(id_signExtImm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_usesRt(id_usesRt), .id_memRead(id_memRead), .id_regWrite(id_regWrite),
    .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_busA(ex_busA), .ex_busB(ex_busB),
    .ex_signExtImm(ex_signExtImm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
    .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  ex_t dut_ex;
  always_comb dut_ex = {ex_valid, ex_pc4, ex_busA, ex_busB, ex_signExtImm, ex_rs,
                        ex_rt, ex_rd, ex_shamt, ex_memRead, ex_regWrite, ex_ctrl};

  int  n_cmp = 0;
  int  n_fail = 0;
  ex_t m_ex = '0;
  int  m_cnt = 0;
  bit  model_ok = 1'b0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic in_t mk(bit rst_n, bit valid, logic [4:0] rs, logic [4:0] rt, bit uses,
                             bit mr, bit rw, bit fl, bit hd, logic [31:0] imm);
    in_t v = '0;
    v.rst_n = rst_n; v.valid = valid; v.rs = rs; v.rt = rt; v.usesRt = uses;
    v.memRead = mr; v.regWrite = rw; v.flush = fl; v.hold = hd; v.imm = imm;
    v.pc4 = 32'h0040_0000 + imm; v.busA = imm ^ 32'hA5A5_0000; v.busB = ~imm;
    v.rd = rt + 5'd1; v.shamt = rs; v.ctrl = 12'h5A5;
    return v;
  endfunction

  // Model: a load sitting in EX stalls any dependent instruction in ID.
  function automatic bit model_stall(in_t v);
    bit dep;
    dep = (m_ex.rt == v.rs) || (v.usesRt && m_ex.rt == v.rt);
    return m_ex.valid && m_ex.memRead && m_ex.rt != 0 && v.valid && dep && !v.flush && !v.hold;
  endfunction

  function automatic void model_step(in_t v);
    bit st = model_stall(v);
    if (!v.rst_n) begin
      m_ex = '0;
      m_cnt = 0;
    end else if (v.hold) begin
      m_ex = m_ex;
    end else if (v.flush || st) begin
      m_ex = '0;
      if (st) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end else begin
      m_ex = '{valid: v.valid, pc4: v.pc4, busA: v.busA, busB: v.busB, imm: v.imm,
               rs: v.rs, rt: v.rt, rd: v.rd, shamt: v.shamt,
               memRead: v.valid & v.memRead, regWrite: v.valid & v.regWrite,
               ctrl: v.valid ? v.ctrl : '0};
    end
  endfunction

  task automatic apply(input in_t v);
    Reset_L = v.rst_n; id_valid = v.valid; id_pc4 = v.pc4; id_busA = v.busA;
    id_busB = v.busB; id_signExtImm = v.imm; id_rs = v.rs; id_rt = v.rt;
    id_rd = v.rd; id_shamt = v.shamt; id_usesRt = v.usesRt; id_memRead = v.memRead;
    id_regWrite = v.regWrite; id_ctrl = v.ctrl; flush = v.flush; ex_hold = v.hold;
  endtask

  // One clock: drive, sample the combinational stall, clock, check against model.
  task automatic cycle(input in_t v, output logic stall_pre);
    apply(v);
    #1;
    stall_pre = hazard_stall;
    if (model_ok) check("stall_model", 192'(hazard_stall), 192'(model_stall(v)));
    model_step(v);
    if (!v.rst_n) model_ok = 1'b1;
    @(posedge CLK);
    #1;
    if (model_ok) begin
      check("ex_model", 192'(dut_ex), 192'(m_ex));
      check("cnt_model", 192'(bubble_cnt), 192'(m_cnt));
    end
  endtask

  vec_t tbl[13];
  logic st;
  in_t  r;

  initial begin
    tbl[0]  = '{mk(0,1,4,3,1,1,1,0,0,32'h1234),     0, 0, 0, 5'd0,  0, 32'h0,        4'd0};
    tbl[1]  = '{mk(0,1,4,3,1,1,1,0,0,32'h1234),     1, 0, 0, 5'd0,  0, 32'h0,        4'd0};
    tbl[2]  = '{mk(1,1,1,5,0,0,1,0,0,32'hFFFF8000), 1, 0, 1, 5'd5,  1, 32'hFFFF8000, 4'd0};
    tbl[3]  = '{mk(1,1,2,8,0,1,1,0,0,32'h4),        1, 0, 1, 5'd8,  1, 32'h4,        4'd0};
    tbl[4]  = '{mk(1,1,8,9,1,0,1,0,0,32'h10),       1, 1, 0, 5'd0,  0, 32'h0,        4'd1};
    tbl[5]  = '{mk(1,1,8,9,1,0,1,0,0,32'h10),       1, 0, 1, 5'd9,  1, 32'h10,       4'd1};
    tbl[6]  = '{mk(1,1,3,0,0,1,1,0,0,32'h20),       1, 0, 1, 5'd0,  1, 32'h20,       4'd1};
    tbl[7]  = '{mk(1,1,0,7,1,0,1,0,0,32'h30),       1, 0, 1, 5'd7,  1, 32'h30,       4'd1};
    tbl[8]  = '{mk(1,1,1,9,0,1,1,0,0,32'h40),       1, 0, 1, 5'd9,  1, 32'h40,       4'd1};
    tbl[9]  = '{mk(1,1,2,9,0,0,1,0,0,32'h50),       1, 0, 1, 5'd9,  1, 32'h50,       4'd1};
    tbl[10] = '{mk(1,1,1,10,0,1,1,0,0,32'h60),      1, 0, 1, 5'd10, 1, 32'h60,       4'd1};
    tbl[11] = '{mk(1,1,10,3,1,0,1,1,0,32'h70),      1, 0, 0, 5'd0,  0, 32'h0,        4'd1};
    tbl[12] = '{mk(1,0,10,4,1,1,1,0,0,32'h80),      1, 0, 0, 5'd4,  0, 32'h80,       4'd1};

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, st);
      if (tbl[i].chk_stall) check($sformatf("tbl%0d_stall", i), 192'(st), 192'(tbl[i].stall));
      check($sformatf("tbl%0d_valid", i), 192'(ex_valid), 192'(tbl[i].valid));
      check($sformatf("tbl%0d_rt", i), 192'(ex_rt), 192'(tbl[i].rt));
      check($sformatf("tbl%0d_regwrite", i), 192'(ex_regWrite), 192'(tbl[i].rw));
      check($sformatf("tbl%0d_imm", i), 192'(ex_signExtImm), 192'(tbl[i].imm));
      check($sformatf("tbl%0d_cnt", i), 192'(bubble_cnt), 192'(tbl[i].cnt));
    end

    // Hold freezes EX for 3 cycles, overriding both the hazard and a flush.
    cycle(mk(1,1,1,8,0,1,1,0,0,32'h99), st);
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1,1,8,2,1,0,1,(i == 1),1,32'h100 + i), st);
      check("hold_stall", 192'(st), 192'(0));
      check("hold_rt", 192'(ex_rt), 192'(8));
      check("hold_memread", 192'(ex_memRead), 192'(1));
      check("hold_imm", 192'(ex_signExtImm), 192'(32'h99));
    end
    cycle(mk(1,1,8,2,1,0,1,0,0,32'h200), st);
    check("post_hold_stall", 192'(st), 192'(1));
    check("post_hold_bubble", 192'(ex_valid), 192'(0));
    check("post_hold_cnt", 192'(bubble_cnt), 192'(2));

    // Saturation: 17 load-use pairs on a 4-bit counter.
    cycle(mk(0,0,0,0,0,0,0,0,0,32'h0), st);
    for (int p = 1; p <= 17; p++) begin
      cycle(mk(1,1,1,6,0,1,1,0,0,32'(p)), st);
      cycle(mk(1,1,6,7,1,0,1,0,0,32'(p)), st);
      cycle(mk(1,1,6,7,1,0,1,0,0,32'(p)), st);
      if (p == 14) check("sat_cnt14", 192'(bubble_cnt), 192'(14));
    end
    check("sat_cnt17", 192'(bubble_cnt), 192'(15));

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 800; i++) begin
      r = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      r.rst_n   = ($urandom_range(0, 99) >= 2);
      r.valid   = ($urandom_range(0, 9) < 8);
      r.rs      = 5'($urandom_range(0, 3));
      r.rt      = 5'($urandom_range(0, 3));
      r.memRead = ($urandom_range(0, 9) < 4);
      r.flush   = ($urandom_range(0, 9) == 0);
      r.hold    = ($urandom_range(0, 99) < 15);
      cycle(r, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register that directly consumes the sign/zero-extended immediate and the other decode-stage products, and presents them registered to the execute stage.
- Contains the load-use hazard detector. It asserts a stall back to PC/IF-ID and inserts a one-cycle bubble into EX.
- Supports flush (taken branch/jump) and hold (downstream stall).
- Counts inserted bubbles for performance monitoring.

Parameters:
- CTRL_W, 12, width of the opaque execute/memory/writeback control bundle passed through.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset_L  in  1  synchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_pc4  in  32  PC+4 of the decoded instruction
- id_busA  in  32  register file read data, rs
- id_busB  in  32  register file read data, rt
- id_signExtImm  in  32  extended immediate from the extender
- id_rs  in  5  source register field
- id_rt  in  5  target register field
- id_rd  in  5  destination register field
- id_shamt  in  5  shift amount field
- id_usesRt  in  1  instruction reads rt as an operand (R-type, store, beq/bne)
- id_memRead  in  1  instruction is a load
- id_regWrite  in  1  instruction writes the register file
- id_ctrl  in  CTRL_W  remaining control bundle
- flush  in  1  squash the instruction in ID (taken branch/jump)
- ex_hold  in  1  execute stage stalled; freeze this register
- ex_valid, ex_pc4, ex_busA, ex_busB, ex_signExtImm, ex_rs, ex_rt, ex_rd, ex_shamt, ex_memRead, ex_regWrite, ex_ctrl  out  matching widths  registered copies of the id_* inputs
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles inserted

Behaviour:
- Reset (Reset_L=0 at edge): all ex_* outputs are 0 and bubble_cnt is 0. hazard_stall then evaluates to 0 because ex_valid=0.
- Load-use detect (combinational), hazard_stall=1 when all of these hold:
  - ex_valid & ex_memRead
  - ex_rt != 0
  - id_valid
  - (ex_rt == id_rs) or (ex_usesRt-side match: id_usesRt & ex_rt == id_rt)
  - flush=0
  - ex_hold=0
- hazard_stall is forced to 0 when flush=1 (the ID instruction dies anyway) or when ex_hold=1 (the upstream freeze is owned by the hold source).
- Per-edge update priority, highest first:
  1. Reset.
  2. ex_hold=1: all ex_* hold their values, no counter change. This wins over flush; the flush source must re-assert flush after the hold.
  3. flush=1: bubble. ex_valid, ex_memRead, ex_regWrite and ex_ctrl become 0. Datapath fields become 0. Counter unchanged.
  4. hazard_stall=1: bubble, as in 3. bubble_cnt increments, saturating at all-ones.
  5. Otherwise: load every ex_* from id_*, with ex_valid=id_valid.
- id_valid=0 loads a bubble with all control fields zeroed; datapath fields are don't-care but loaded.
- Latency is 1 cycle from ID to EX.
- A load-use stall lasts exactly one cycle: the bubble clears ex_memRead, so the held ID instruction advances on the next edge.
- Back-to-back loads into dependent users each produce exactly one bubble.
- Reset mid-stall clears state; hazard_stall drops in the same cycle Reset_L is sampled low only after the edge (it is combinational on registered ex_*).
- No arithmetic on the datapath; widths pass through unmodified.

Test Plan:
- Reset: hold Reset_L=0 for 2 cycles with nonzero id_* -> all ex_*=0, hazard_stall=0, bubble_cnt=0.
- Pass-through: id_valid=1, id_signExtImm=0xFFFF8000, id_rt=5, id_memRead=0 -> next cycle ex_signExtImm=0xFFFF8000, ex_rt=5, ex_valid=1.
- Load-use:
  - Stimulus: lw into rt=8 is in EX; ID has add with rs=8.
  - Required: hazard_stall=1 for exactly one cycle; next EX is a bubble (ex_valid=0, ex_regWrite=0); bubble_cnt=1; the add enters EX on the following cycle.
- No hazard on $zero or usesRt=0: lw with rt=0 followed by a user of r0 -> hazard_stall=0. lw rt=9 followed by addi with rt=9 (id_usesRt=0) -> hazard_stall=0.
- Flush vs hazard: load-use condition present with flush=1 -> hazard_stall=0, EX gets a bubble, bubble_cnt unchanged.
- Hold:
  - Stimulus: ex_hold=1 for 3 cycles while id_* changes, with flush=1 in one of those cycles.
  - Required: ex_* frozen throughout; hazard_stall=0 throughout.
- Saturation: with CNT_W=4, create 17 load-use pairs -> bubble_cnt stays at 15.
